oddr_tx_gearbox: RTL and testbench

//  Parametrised successor to the single-register DDR output: takes whole words on a valid/ready stream,

---
 rtl/eth_phy_pkg.sv | 16 +
 rtl/oddr.sv | 35 +++
 rtl/oddr_tx_gearbox.sv | 171 +++++++++++++++++
 tb/tb_oddr_tx_gearbox.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_phy_pkg.sv
// Shared types and helpers for the Ethernet PHY-side pin logic.
package eth_phy_pkg;

    typedef enum logic {
        MODE_DDR = 1'b0,
        MODE_SDR = 1'b1
    } oddr_mode_t;

    // Width of a counter able to index every slice of a 2*beats-slice word.
    function automatic int unsigned slice_cnt_w(input int unsigned beats);
        int unsigned w;
        w = $clog2(2 * beats);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/oddr.sv
// DDR output register: d1 is driven while clk is high, d2 while clk is low,
// both captured on the rising edge.
module oddr #(
    parameter string       TARGET      = "GENERIC",
    parameter string       IODDR_STYLE = "IODDR2",
    parameter int unsigned WIDTH       = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d1_reg;
    logic [WIDTH-1:0] d2_reg;

    always_ff @(posedge clk) begin
        d1_reg <= d1;
        d2_reg <= d2;
    end

    if ((TARGET == "XILINX" || TARGET == "ALTERA") && IODDR_STYLE == "IODDR") begin : g_same_edge
        assign q = clk ? d1_reg : d2_reg;
    end else begin : g_retimed
        // Falling half re-registered on the falling edge so it only changes mid-cycle.
        logic [WIDTH-1:0] d2_neg;

        always_ff @(negedge clk) begin
            d2_neg <= d2_reg;
        end

        assign q = clk ? d1_reg : d2_neg;
    end

endmodule

// File: rtl/oddr_tx_gearbox.sv
// Word-stream to DDR pin gearbox: slices valid/ready words into WIDTH-bit lanes
// with a TX_EN/TX_ER style control lane, per-word DDR or SDR, one-word hold buffer.
module oddr_tx_gearbox
    import eth_phy_pkg::*;
#(
    parameter string            TARGET      = "GENERIC",
    parameter string            IODDR_STYLE = "IODDR2",
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      BEATS       = 2,
    parameter logic [WIDTH-1:0] IDLE_VALUE  = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2*WIDTH*BEATS-1:0] s_data,
    input  logic                     s_err,
    input  logic                     s_sdr,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [WIDTH-1:0]         q,
    output logic                     q_ctl,
    output logic                     busy
);

    localparam int unsigned     DW       = 2 * WIDTH * BEATS;
    localparam int unsigned     CW       = slice_cnt_w(BEATS);
    localparam logic [CW-1:0]   LAST_DDR = CW'(BEATS - 1);
    localparam logic [CW-1:0]   LAST_SDR = CW'(2 * BEATS - 1);

    logic             sh_active, nxt_sh_active;
    logic [DW-1:0]    sh_data,   nxt_sh_data;
    logic             sh_err,    nxt_sh_err;
    oddr_mode_t       sh_mode,   nxt_sh_mode;
    logic [CW-1:0]    sh_cnt,    nxt_sh_cnt;

    logic             hold_valid, nxt_hold_valid;
    logic [DW-1:0]    hold_data,  nxt_hold_data;
    logic             hold_err,   nxt_hold_err;
    oddr_mode_t       hold_mode,  nxt_hold_mode;

    logic [WIDTH-1:0] st_d1, nxt_st_d1;
    logic [WIDTH-1:0] st_d2, nxt_st_d2;
    logic             st_ctl1, nxt_st_ctl1;
    logic             st_ctl2, nxt_st_ctl2;

    logic             sh_last;
    logic             sh_free;
    logic             accept;
    logic [DW-1:0]    word_shr;

    assign s_ready = !hold_valid && !rst;
    assign accept  = s_valid && s_ready;
    assign sh_last = (sh_cnt == ((sh_mode == MODE_SDR) ? LAST_SDR : LAST_DDR));
    assign sh_free = !sh_active || sh_last;
    assign busy    = (sh_active || hold_valid) && !rst;

    always_comb begin
        nxt_sh_active  = sh_active;
        nxt_sh_data    = sh_data;
        nxt_sh_err     = sh_err;
        nxt_sh_mode    = sh_mode;
        nxt_sh_cnt     = sh_cnt;
        nxt_hold_valid = hold_valid;
        nxt_hold_data  = hold_data;
        nxt_hold_err   = hold_err;
        nxt_hold_mode  = hold_mode;

        if (sh_free) begin
            nxt_sh_cnt = '0;
            if (hold_valid) begin
                nxt_sh_active  = 1'b1;
                nxt_sh_data    = hold_data;
                nxt_sh_err     = hold_err;
                nxt_sh_mode    = hold_mode;
                nxt_hold_valid = 1'b0;
            end else if (accept) begin
                nxt_sh_active = 1'b1;
                nxt_sh_data   = s_data;
                nxt_sh_err    = s_err;
                nxt_sh_mode   = oddr_mode_t'(s_sdr);
            end else begin
                nxt_sh_active = 1'b0;
            end
        end else begin
            nxt_sh_cnt = sh_cnt + 1'b1;
            if (accept) begin
                nxt_hold_valid = 1'b1;
                nxt_hold_data  = s_data;
                nxt_hold_err   = s_err;
                nxt_hold_mode  = oddr_mode_t'(s_sdr);
            end
        end
    end

    // Staging is derived from the shifter's next state so a bypassed word
    // reaches the oddr inputs on the same edge it is accepted.
    always_comb begin
        nxt_st_d1   = IDLE_VALUE;
        nxt_st_d2   = IDLE_VALUE;
        nxt_st_ctl1 = 1'b0;
        nxt_st_ctl2 = 1'b0;
        word_shr    = '0;
        if (nxt_sh_active) begin
            if (nxt_sh_mode == MODE_SDR) begin
                word_shr  = nxt_sh_data >> (WIDTH * nxt_sh_cnt);
                nxt_st_d1 = word_shr[WIDTH-1:0];
                nxt_st_d2 = word_shr[WIDTH-1:0];
            end else begin
                word_shr  = nxt_sh_data >> (2 * WIDTH * nxt_sh_cnt);
                nxt_st_d1 = word_shr[WIDTH-1:0];
                nxt_st_d2 = word_shr[2*WIDTH-1:WIDTH];
            end
            nxt_st_ctl1 = 1'b1;
            nxt_st_ctl2 = !nxt_sh_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_active  <= 1'b0;
            sh_data    <= '0;
            sh_err     <= 1'b0;
            sh_mode    <= MODE_DDR;
            sh_cnt     <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_err   <= 1'b0;
            hold_mode  <= MODE_DDR;
            st_d1      <= IDLE_VALUE;
            st_d2      <= IDLE_VALUE;
            st_ctl1    <= 1'b0;
            st_ctl2    <= 1'b0;
        end else begin
            sh_active  <= nxt_sh_active;
            sh_data    <= nxt_sh_data;
            sh_err     <= nxt_sh_err;
            sh_mode    <= nxt_sh_mode;
            sh_cnt     <= nxt_sh_cnt;
            hold_valid <= nxt_hold_valid;
            hold_data  <= nxt_hold_data;
            hold_err   <= nxt_hold_err;
            hold_mode  <= nxt_hold_mode;
            st_d1      <= nxt_st_d1;
            st_d2      <= nxt_st_d2;
            st_ctl1    <= nxt_st_ctl1;
            st_ctl2    <= nxt_st_ctl2;
        end
    end

    oddr #(
        .TARGET      (TARGET),
        .IODDR_STYLE (IODDR_STYLE),
        .WIDTH       (WIDTH)
    ) u_oddr_data (
        .clk (clk),
        .d1  (st_d1),
        .d2  (st_d2),
        .q   (q)
    );

    oddr #(
        .TARGET      (TARGET),
        .IODDR_STYLE (IODDR_STYLE),
        .WIDTH       (1)
    ) u_oddr_ctl (
        .clk (clk),
        .d1  (st_ctl1),
        .d2  (st_ctl2),
        .q   (q_ctl)
    );

endmodule

// File: tb/tb_oddr_tx_gearbox.sv
// Randomised bench for oddr_tx_gearbox against a word-timeline reference model:
// each accepted word is scheduled to start at max(accept edge, end of previous word).
module tb_oddr_tx_gearbox;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned BEATS = 2;
    localparam int unsigned DW    = 2 * WIDTH * BEATS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DW-1:0]    s_data = '0;
    logic             s_err = 1'b0;
    logic             s_sdr = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] q;
    logic             q_ctl;
    logic             busy;

    always #5 clk = ~clk;

    oddr_tx_gearbox #(
        .TARGET      ("GENERIC"),
        .IODDR_STYLE ("IODDR2"),
        .WIDTH       (WIDTH),
        .BEATS       (BEATS),
        .IDLE_VALUE  (4'h0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_err   (s_err),
        .s_sdr   (s_sdr),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .q       (q),
        .q_ctl   (q_ctl),
        .busy    (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Word timeline: accept edge, first staging edge, number of staged cycles.
    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          sdr;
        int            ta;
        int            s;
        int            len;
    } word_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          sdr;
    } src_t;

    word_t tl[$];
    src_t  src[$];
    bit    presenting = 1'b0;
    bit    acc_last   = 1'b0;
    int    gap_pct    = 0;

    function automatic bit m_hold(input int e);
        foreach (tl[k]) if (tl[k].ta <= e && e < tl[k].s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_active(input int e);
        foreach (tl[k]) if (tl[k].s <= e && e < tl[k].s + tl[k].len) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_end();
        if (tl.size() == 0) return 0;
        return tl[tl.size()-1].s + tl[tl.size()-1].len;
    endfunction

    function automatic logic [WIDTH-1:0] slice_of(input logic [DW-1:0] d, input int k);
        logic [DW-1:0] t;
        t = d >> (WIDTH * k);
        return t[WIDTH-1:0];
    endfunction

    // Reset at edge r drops every slice that would have been staged at r or later.
    task automatic m_reset(input int r);
        for (int k = tl.size() - 1; k >= 0; k--) begin
            if (tl[k].s >= r) tl.delete(k);
            else if (tl[k].s + tl[k].len > r) tl[k].len = r - tl[k].s;
        end
    endtask

    // Pin values driven in the cycle after the edge following staging edge t.
    task automatic m_pins(input int t, output logic [WIDTH-1:0] rq, output logic rc,
                          output logic [WIDTH-1:0] fq, output logic fc);
        int i;
        rq = '0; fq = '0; rc = 1'b0; fc = 1'b0;
        foreach (tl[k]) begin
            if (tl[k].s <= t && t < tl[k].s + tl[k].len) begin
                i = t - tl[k].s;
                if (tl[k].sdr) begin
                    rq = slice_of(tl[k].data, i);
                    fq = slice_of(tl[k].data, i);
                end else begin
                    rq = slice_of(tl[k].data, 2 * i);
                    fq = slice_of(tl[k].data, 2 * i + 1);
                end
                rc = 1'b1;
                fc = !tl[k].err;
            end
        end
    endtask

    task automatic drive_source();
        src_t w;
        if (acc_last) presenting = 1'b0;
        if (!presenting && src.size() > 0 && $urandom_range(99) >= gap_pct) begin
            w          = src.pop_front();
            s_data     = w.data;
            s_err      = w.err;
            s_sdr      = w.sdr;
            presenting = 1'b1;
        end
        s_valid = presenting;
        if (!presenting) begin
            s_data = DW'($urandom);
            s_err  = 1'($urandom);
            s_sdr  = 1'($urandom);
        end
    endtask

    task automatic step();
        logic [WIDTH-1:0] rq, fq;
        logic             rc, fc;
        bit               acc;
        word_t            w;
        acc = s_valid && !rst && !m_hold(cyc);
        if (rst) m_reset(cyc + 1);
        @(posedge clk);
        cyc++;
        if (acc) begin
            w.data = s_data;
            w.err  = s_err;
            w.sdr  = s_sdr;
            w.ta   = cyc;
            w.s    = (m_end() > cyc) ? m_end() : cyc;
            w.len  = s_sdr ? 2 * BEATS : BEATS;
            tl.push_back(w);
        end
        acc_last = acc;
        m_pins(cyc - 1, rq, rc, fq, fc);
        #1;
        if (cyc >= 2) begin
            check_eq("q_rise", q, rq);
            check_eq("ctl_rise", q_ctl, rc);
        end
        check_eq("s_ready", s_ready, !rst && !m_hold(cyc));
        check_eq("busy", busy, !rst && (m_hold(cyc) || m_active(cyc)));
        drive_source();
        @(negedge clk);
        #1;
        if (cyc >= 2) begin
            check_eq("q_fall", q, fq);
            check_eq("ctl_fall", q_ctl, fc);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic e, input logic sdr);
        src_t w;
        w.data = d;
        w.err  = e;
        w.sdr  = sdr;
        src.push_back(w);
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while ((src.size() > 0 || presenting || m_hold(cyc) || m_active(cyc)) && n < max_cycles) begin
            step();
            n++;
        end
        if (n >= max_cycles) check_eq("drain_timeout", 32'(n), 32'(max_cycles + 1));
        repeat (3) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for three edges with a word already offered.
        gap_pct = 0;
        push_word(16'hA5C3, 1'b0, 1'b0);
        drive_source();
        repeat (3) step();
        rst = 1'b0;
        run_until_idle(50);

        push_word(16'hA5C3, 1'b0, 1'b1);
        run_until_idle(50);

        push_word(16'h1111, 1'b0, 1'b0);
        push_word(16'h2222, 1'b0, 1'b0);
        push_word(16'h3333, 1'b0, 1'b0);
        run_until_idle(50);

        push_word(16'hA5C3, 1'b1, 1'b0);
        run_until_idle(50);

        // Reset one edge after the first word is staged; the source withdraws.
        push_word(16'hA5C3, 1'b0, 1'b0);
        push_word(16'h5A5A, 1'b0, 1'b0);
        begin
            int n = 0;
            do begin
                step();
                n++;
            end while (!acc_last && n < 20);
            if (n >= 20) check_eq("accept_timeout", 32'(n), 32'd0);
        end
        rst        = 1'b1;
        presenting = 1'b0;
        src.delete();
        s_valid    = 1'b0;
        step();
        rst = 1'b0;
        run_until_idle(50);

        // Random words, mixed modes, random source gaps, one mid-stream reset.
        for (int round = 0; round < 4; round++) begin
            gap_pct = (round == 0) ? 0 : int'($urandom_range(70));
            for (int k = 0; k < 20; k++)
                push_word(DW'($urandom), ($urandom_range(3) == 0), 1'($urandom));
            if (round == 2) begin
                repeat (15) step();
                rst = 1'b1;
                repeat (1 + $urandom_range(1)) step();
                rst = 1'b0;
            end
            run_until_idle(1000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
